// File: rtl/mux16_sched_pkg.sv
// Shared constants, FSM state type and pointer helper for the 16-channel
// round-robin mux scheduler.
package mux16_sched_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Round-robin pointer advance; the 4-bit width gives the 15->0 wrap.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: finds the first set request bit at or
// above ptr, wrapping 15->0. Priority overrides are applied by the caller.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  logic [SEL_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    any    = 1'b0;
    winner = ptr;
    w_idx  = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = ptr + SEL_W'(i);
      if (req[w_idx]) begin
        any    = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 channels.
// IDLE picks a winner and drives mux_sel, SELECT captures the muxed bit,
// HOLD presents it on a valid/ready port and acks the channel on handshake.
// Optional build macro MUX16_SCHED_PRIO0_EN: channel 0 always wins when it
// requests and its grants leave the round-robin pointer untouched.
module mux16_rr_sched
  import mux16_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  data_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic             out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_CH-1:0]  ack,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] r_mux_sel;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_data;
  logic             r_out_valid;
  logic [N_CH-1:0]  r_ack;
  logic             w_pick_any;
  logic [SEL_W-1:0] w_pick_win;
  logic [SEL_W-1:0] w_grant;
  logic             w_hs;
  logic             w_ptr_upd;

  rr_pick16 u_pick (
    .req    (req),
    .ptr    (r_rr_ptr),
    .any    (w_pick_any),
    .winner (w_pick_win)
  );

`ifdef MUX16_SCHED_PRIO0_EN
  // Channel 0 pre-empts the rotation and never moves the pointer.
  assign w_grant   = req[0] ? '0 : w_pick_win;
  assign w_ptr_upd = (r_out_sel != '0);
`else
  assign w_grant   = w_pick_win;
  assign w_ptr_upd = 1'b1;
`endif

  assign w_hs = (r_state == HOLD) && r_out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: grant in IDLE, one settle cycle, hold until handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = SELECT;
      SELECT:  w_state_nxt = HOLD;
      HOLD:    if (w_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select, capture, output and ack registers; ack is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_mux_sel   <= '0;
      r_out_data  <= 1'b0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= '0;
    end else begin
      r_ack <= '0;
      if (r_state == IDLE && w_pick_any) begin
        r_mux_sel <= w_grant;
      end
      if (r_state == SELECT) begin
        r_out_data  <= data_in[r_mux_sel];
        r_out_sel   <= r_mux_sel;
        r_out_valid <= 1'b1;
      end
      if (w_hs) begin
        r_out_valid <= 1'b0;
        r_ack       <= N_CH'(1) << r_out_sel;
        if (w_ptr_upd) r_rr_ptr <= next_ptr(r_out_sel);
      end
    end
  end

  assign mux_sel   = r_mux_sel;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
  assign ack       = r_ack;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus randomized
// transactions compared against a behavioural arbitration model.
module tb_mux16_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] data_in;
  logic [3:0]  mux_sel;
  logic        out_data;
  logic [3:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ack;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  mux16_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .mux_sel   (mux_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: nearest requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [15:0] r);
`ifdef MUX16_SCHED_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < 16; i++) begin
      int c;
      c = (m_ptr + i) % 16;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_served(input int w);
`ifdef MUX16_SCHED_PRIO0_EN
    if (w != 0) m_ptr = (w + 1) % 16;
`else
    m_ptr = (w + 1) % 16;
`endif
  endfunction

  // One full transaction starting from IDLE; d is data_in during SELECT.
  task automatic do_txn(input logic [15:0] r, input logic [15:0] d, input int bp, input bit drop);
    int w;
    logic cap;
    w = model_pick(r);
    req       = r;
    data_in   = 16'($urandom);
    out_ready = 1'($urandom);
    step();
    chk("grant_sel", 32'(mux_sel), 32'(w));
    chk("sel_busy", 32'(busy), 32'd1);
    chk("sel_valid", 32'(out_valid), 32'd0);
    if (drop) req = r & ~(16'd1 << w);
    data_in   = d;
    cap       = d[w];
    out_ready = 1'($urandom);
    step();
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_data", 32'(out_data), 32'(cap));
    chk("cap_sel", 32'(out_sel), 32'(w));
    out_ready = 1'b0;
    for (int k = 0; k < bp; k++) begin
      data_in = 16'($urandom);
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(cap));
      chk("bp_sel", 32'(out_sel), 32'(w));
      chk("bp_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    step();
    model_served(w);
    chk("ack", 32'(ack), 32'(16'd1 << w));
    chk("ack_valid", 32'(out_valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_mux_hold", 32'(mux_sel), 32'(w));
    chk("rr_ptr", 32'(dut.r_rr_ptr), 32'(m_ptr));
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    data_in   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mux", 32'(mux_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_osel", 32'(out_sel), 32'd0);
    chk("rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    rst_n = 1'b1;

    // Basic latency case on channel 4.
    do_txn(16'h0010, 16'h0010, 0, 1'b0);

    // No requests: stays idle, mux_sel keeps last grant.
    req = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mux", 32'(mux_sel), 32'd4);
      chk("idle_ack", 32'(ack), 32'd0);
    end

    // Move pointer to 14, then all request: wrap ordering.
    do_txn(16'h2000, 16'($urandom), 0, 1'b0);
    for (int k = 0; k < 4; k++) do_txn(16'hFFFF, 16'($urandom), 0, 1'b0);

    // Backpressure for 5 cycles.
    do_txn(16'h0100, 16'h0100, 5, 1'b0);
    do_txn(16'h0100, 16'h0000, 5, 1'b0);

    // Request drop right after grant on channel 7.
    do_txn(16'h0080, 16'h0080, 1, 1'b1);

    // Pointer to 3, then channels 0 and 3 request.
    do_txn(16'h0004, 16'($urandom), 0, 1'b0);
    do_txn(16'h0009, 16'($urandom), 0, 1'b0);
    do_txn(16'h0008, 16'($urandom), 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (r == 16'h0) r = 16'h8000;
      do_txn(r, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Asynchronous reset while holding a grant.
    do_txn(16'h0200, 16'($urandom), 0, 1'b0);
    req       = 16'h0400;
    out_ready = 1'b0;
    step();
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mux", 32'(mux_sel), 32'd0);
    chk("arst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    #2 rst_n = 1'b1;
    m_ptr = 0;
    req = '0;
    out_ready = 1'b1;
    step();
    chk("post_rst_ack", 32'(ack), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    do_txn(16'h8001, 16'($urandom), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
